// File: rtl/simd_vec_exec_pkg.sv
// Shared definitions for the SIMD vector execute stage.
// Holds the vector/lane/regfile geometry, the FSM state type and the
// per-lane int8 helpers (saturating clamp and ReLU).
package simd_pkg;

  localparam int DATA_W = 256;
  localparam int LANE_W = 8;
  localparam int NLANE  = DATA_W / LANE_W;
  localparam int IDX_W  = 5;
  localparam int MUX_W  = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    HOLD_A = 1'b1
  } state_t;

  // Clamp a 9-bit signed sum into the int8 range [-128, 127].
  function automatic logic [7:0] sat8(input logic signed [8:0] s);
    logic [7:0] r;
    if (s > 9'sd127) begin
      r = 8'h7F;
    end else if (s < -9'sd128) begin
      r = 8'h80;
    end else begin
      r = s[7:0];
    end
    return r;
  endfunction

  // Force negative int8 values to zero.
  function automatic logic [7:0] relu8(input logic [7:0] x);
    logic [7:0] r;
    if (x[7]) begin
      r = 8'h00;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/simd_vec_exec_if.sv
// Beat/write-back bundle of the SIMD execute stage.
// master: upstream pre-register + write-back consumer side (drives i_*, reads o_*).
// slave : the execute stage itself (reads i_*, drives o_*).
interface simd_vec_exec_if;
  import simd_pkg::*;

  logic [DATA_W-1:0] i_data;
  logic              i_data_v;
  logic [IDX_W-1:0]  i_rf_idx;
  logic [MUX_W-1:0]  i_rf_mux;
  logic              i_en_simd;
  logic              i_en_vadd;
  logic              i_en_relu;
  logic              i_flush;
  logic              i_clr_sat;
  logic [DATA_W-1:0] o_wb_data;
  logic              o_wb_v;
  logic [IDX_W-1:0]  o_wb_idx;
  logic [MUX_W-1:0]  o_wb_mux;
  logic              o_pend;
  logic              o_sat;

  modport master (
    output i_data, i_data_v, i_rf_idx, i_rf_mux, i_en_simd, i_en_vadd,
           i_en_relu, i_flush, i_clr_sat,
    input  o_wb_data, o_wb_v, o_wb_idx, o_wb_mux, o_pend, o_sat
  );

  modport slave (
    input  i_data, i_data_v, i_rf_idx, i_rf_mux, i_en_simd, i_en_vadd,
           i_en_relu, i_flush, i_clr_sat,
    output o_wb_data, o_wb_v, o_wb_idx, o_wb_mux, o_pend, o_sat
  );

endinterface

// File: rtl/simd_vec_exec_lane_alu.sv
// One int8 lane of the execute stage (purely combinational).
// a       : held operand A lane
// b       : incoming beat lane
// en_add  : 1 -> sat8(a + b), 0 -> b passes through
// en_relu : zero a negative result after the add/pass stage
// res     : lane result
// sat     : the add overflowed and was clamped (never set by ReLU)
module simd_lane_alu
  import simd_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              en_add,
  input  logic              en_relu,
  output logic [LANE_W-1:0] res,
  output logic              sat
);

  logic signed [LANE_W:0] sum_s;
  logic [LANE_W-1:0]      pre_s;

  // Sign-extended add, clamp, then optional ReLU.
  always_comb begin
    sum_s = $signed({a[LANE_W-1], a}) + $signed({b[LANE_W-1], b});
    if (en_add) begin
      pre_s = sat8(sum_s);
      // Overflow of a 9-bit sum shows as disagreement of its top two bits.
      sat   = sum_s[LANE_W] ^ sum_s[LANE_W-1];
    end else begin
      pre_s = b;
      sat   = 1'b0;
    end
    if (en_relu) begin
      res = relu8(pre_s);
    end else begin
      res = pre_s;
    end
  end

endmodule

// File: rtl/simd_vec_exec.sv
// Vector SIMD execute stage.
// clk, rst : clock and synchronous active-high reset
// bus      : beat inputs (data, valid, regfile idx/mux, simd/vadd/relu enables,
//            flush, sat clear) and registered write-back outputs (data, valid
//            pulse, idx, mux), plus o_pend (operand A held) and sticky o_sat.
// A vadd operation takes two accepted beats: the first is held as operand A,
// the second completes the lane-wise saturating add. Non-vadd beats pass
// through (optionally ReLU'd) at any time without disturbing a held A.
module simd_vec_exec
  import simd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  simd_vec_exec_if.slave  bus
);

  state_t            state_r;
  logic [DATA_W-1:0] opa_r;
  logic [DATA_W-1:0] wb_data_r;
  logic              wb_v_r;
  logic [IDX_W-1:0]  wb_idx_r;
  logic [MUX_W-1:0]  wb_mux_r;
  logic              pend_r;
  logic              sat_r;

  logic              accept_s;
  logic              complete_add_s;
  logic [DATA_W-1:0] res_s;
  logic [NLANE-1:0]  lane_sat_s;

  assign accept_s       = bus.i_data_v & bus.i_en_simd;
  // Second vadd beat while A is held; a flush in the same cycle kills it.
  assign complete_add_s = accept_s & bus.i_en_vadd & ~bus.i_flush & (state_r == HOLD_A);

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    simd_lane_alu u_alu (
      .a       (opa_r[k*LANE_W +: LANE_W]),
      .b       (bus.i_data[k*LANE_W +: LANE_W]),
      .en_add  (bus.i_en_vadd),
      .en_relu (bus.i_en_relu),
      .res     (res_s[k*LANE_W +: LANE_W]),
      .sat     (lane_sat_s[k])
    );
  end

  // Operand FSM, write-back registers and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      opa_r     <= {DATA_W{1'b0}};
      wb_data_r <= {DATA_W{1'b0}};
      wb_v_r    <= 1'b0;
      wb_idx_r  <= {IDX_W{1'b0}};
      wb_mux_r  <= {MUX_W{1'b0}};
      pend_r    <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      wb_v_r <= 1'b0;
      if (accept_s && !bus.i_en_vadd) begin
        wb_v_r    <= 1'b1;
        wb_data_r <= res_s;
        wb_idx_r  <= bus.i_rf_idx;
        wb_mux_r  <= bus.i_rf_mux;
      end else if (accept_s && !bus.i_flush) begin
        case (state_r)
          IDLE: begin
            opa_r   <= bus.i_data;
            state_r <= HOLD_A;
            pend_r  <= 1'b1;
          end
          HOLD_A: begin
            wb_v_r    <= 1'b1;
            wb_data_r <= res_s;
            wb_idx_r  <= bus.i_rf_idx;
            wb_mux_r  <= bus.i_rf_mux;
            state_r   <= IDLE;
            pend_r    <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            pend_r  <= 1'b0;
          end
        endcase
      end
      // Flush overrides any transition taken above.
      if (bus.i_flush) begin
        state_r <= IDLE;
        pend_r  <= 1'b0;
        opa_r   <= {DATA_W{1'b0}};
      end
      // Set beats clear when both happen in one cycle.
      if (complete_add_s && (|lane_sat_s)) begin
        sat_r <= 1'b1;
      end else if (bus.i_clr_sat) begin
        sat_r <= 1'b0;
      end
    end
  end

  assign bus.o_wb_data = wb_data_r;
  assign bus.o_wb_v    = wb_v_r;
  assign bus.o_wb_idx  = wb_idx_r;
  assign bus.o_wb_mux  = wb_mux_r;
  assign bus.o_pend    = pend_r;
  assign bus.o_sat     = sat_r;

endmodule

// File: tb/tb_simd_vec_exec.sv
// Scoreboard bench for simd_vec_exec: the driver updates a lane-level
// reference model and queues expected write-backs; an independent monitor
// pops and compares whenever o_wb_v is seen.
module tb_simd_vec_exec;
  import simd_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [IDX_W-1:0]  idx;
    logic [MUX_W-1:0]  mux;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_vec_exec_if bus_if ();

  simd_vec_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  exp_t              exp_q[$];
  int                checks   = 0;
  int                failures = 0;
  logic [DATA_W-1:0] m_opa;
  bit                m_have_a = 1'b0;
  bit                m_sat    = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] fill(input logic [7:0] b);
    return {NLANE{b}};
  endfunction

  function automatic logic [DATA_W-1:0] rand_vec();
    logic [DATA_W-1:0] v;
    for (int w = 0; w < DATA_W/32; w++) v[32*w +: 32] = $urandom;
    // Bias some lanes toward the int8 extremes to provoke saturation.
    for (int k = 0; k < NLANE; k++) begin
      case ($urandom_range(0, 5))
        0: v[8*k +: 8] = 8'h7F;
        1: v[8*k +: 8] = 8'h80;
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic idle_inputs();
    bus_if.i_data    = {DATA_W{1'b0}};
    bus_if.i_data_v  = 1'b0;
    bus_if.i_rf_idx  = {IDX_W{1'b0}};
    bus_if.i_rf_mux  = {MUX_W{1'b0}};
    bus_if.i_en_simd = 1'b0;
    bus_if.i_en_vadd = 1'b0;
    bus_if.i_en_relu = 1'b0;
    bus_if.i_flush   = 1'b0;
    bus_if.i_clr_sat = 1'b0;
  endtask

  // One cycle of stimulus; the model is stepped before the edge.
  task automatic beat(input bit v, input bit simd, input bit vadd, input bit relu,
                      input bit flush, input bit clr, input logic [DATA_W-1:0] d,
                      input logic [IDX_W-1:0] idx, input logic [MUX_W-1:0] mux);
    exp_t e;
    bit   acc;
    bit   sat_evt;
    int   s;
    @(negedge clk);
    bus_if.i_data    = d;
    bus_if.i_data_v  = v;
    bus_if.i_rf_idx  = idx;
    bus_if.i_rf_mux  = mux;
    bus_if.i_en_simd = simd;
    bus_if.i_en_vadd = vadd;
    bus_if.i_en_relu = relu;
    bus_if.i_flush   = flush;
    bus_if.i_clr_sat = clr;
    acc     = v & simd;
    sat_evt = 1'b0;
    e.idx   = idx;
    e.mux   = mux;
    if (acc && !vadd) begin
      e.d = d;
      for (int k = 0; k < NLANE; k++)
        if (relu && $signed(d[8*k +: 8]) < 0) e.d[8*k +: 8] = 8'h00;
      exp_q.push_back(e);
    end else if (acc && !flush) begin
      if (!m_have_a) begin
        m_opa    = d;
        m_have_a = 1'b1;
      end else begin
        for (int k = 0; k < NLANE; k++) begin
          s = int'($signed(m_opa[8*k +: 8])) + int'($signed(d[8*k +: 8]));
          if (s > 127) begin
            s = 127;
            sat_evt = 1'b1;
          end else if (s < -128) begin
            s = -128;
            sat_evt = 1'b1;
          end
          if (relu && s < 0) s = 0;
          e.d[8*k +: 8] = 8'(s);
        end
        exp_q.push_back(e);
        m_have_a = 1'b0;
      end
    end
    if (flush) m_have_a = 1'b0;
    if (sat_evt) m_sat = 1'b1;
    else if (clr) m_sat = 1'b0;
    @(posedge clk);
    #2;
    check("o_pend", bus_if.o_pend, m_have_a);
    check("o_sat", bus_if.o_sat, m_sat);
  endtask

  task automatic nop();
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {DATA_W{1'b0}}, 5'd0, 2'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst      = 1'b0;
    m_have_a = 1'b0;
    m_sat    = 1'b0;
    exp_q.delete();
    check("rst_wb_v", bus_if.o_wb_v, 1'b0);
    check("rst_wb_data", bus_if.o_wb_data, {DATA_W{1'b0}});
    check("rst_wb_idx", bus_if.o_wb_idx, {IDX_W{1'b0}});
    check("rst_wb_mux", bus_if.o_wb_mux, {MUX_W{1'b0}});
    check("rst_pend", bus_if.o_pend, 1'b0);
    check("rst_sat", bus_if.o_sat, 1'b0);
  endtask

  // Monitor: every write-back pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.o_wb_v === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual o_wb_v=1 required o_wb_v=0 (data=%h)",
                   bus_if.o_wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_data", bus_if.o_wb_data, e.d);
          check("wb_idx", bus_if.o_wb_idx, e.idx);
          check("wb_mux", bus_if.o_wb_mux, e.mux);
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    idle_inputs();
    do_reset();

    // Pass-through of alternating extreme lanes.
    for (int k = 0; k < NLANE; k++) d[8*k +: 8] = (k % 2 == 0) ? 8'h80 : 8'h7F;
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d, 5'd3, 2'd1);
    nop();

    // ReLU only.
    d = fill(8'hF0);
    d[7:0] = 8'h05;
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, d, 5'd9, 2'd2);
    nop();

    // Positive saturation, then clear.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h70), 5'd1, 2'd0);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h20), 5'd7, 2'd0);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {DATA_W{1'b0}}, 5'd0, 2'd0);

    // Negative overflow followed by ReLU.
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, fill(8'h90), 5'd2, 2'd1);
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, fill(8'hE0), 5'd12, 2'd3);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {DATA_W{1'b0}}, 5'd0, 2'd0);

    // Interleaved pass-through while A is held, back-to-back.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h11), 5'd4, 2'd0);
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, fill(8'hC3), 5'd5, 2'd1);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h22), 5'd6, 2'd2);
    nop();

    // Flush drops A; the next vadd beat becomes a fresh A.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h01), 5'd8, 2'd0);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {DATA_W{1'b0}}, 5'd0, 2'd0);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h02), 5'd9, 2'd0);
    // Flush with a vadd beat in the same cycle: both discarded.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, fill(8'h03), 5'd10, 2'd0);
    // Pass-through in a flush cycle is still processed.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h04), 5'd11, 2'd0);
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fill(8'h85), 5'd13, 2'd3);
    nop();

    // Mid-operation reset, then en_simd gating.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h7F), 5'd14, 2'd0);
    do_reset();
    beat(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fill(8'h55), 5'd15, 2'd1);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fill(8'h66), 5'd16, 2'd1);
    nop();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        beat($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
             rand_vec(), 5'($urandom), 2'($urandom));
      end
    end
    nop();
    nop();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simd_vec_exec.md
Name: simd_vec_exec

Overview:
- Vector SIMD execute stage. Sits directly downstream of the SIMD input pre-register.
- Consumes the registered 256-bit vector beat plus its control flags. Performs lane-wise int8 vector add (two-beat operand pairing) and/or ReLU.
- Emits one registered write-back beat per completed operation toward the vector regfile write port.

Parameters:
- DATA_W, 256, vector width in bits
- LANE_W, 8, lane width in bits; lanes are signed two's complement; NLANE = DATA_W/LANE_W = 32
- IDX_W, 5, regfile index width
- MUX_W, 2, regfile mux-select width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_data  in  DATA_W  vector beat; lane k = bits [8k+7:8k]
- i_data_v  in  1  beat valid
- i_rf_idx  in  IDX_W  destination regfile index for the result
- i_rf_mux  in  MUX_W  destination regfile mux select
- i_en_simd  in  1  beat targets the SIMD unit
- i_en_vadd  in  1  beat is a vector-add operand
- i_en_relu  in  1  apply ReLU to the result
- i_flush  in  1  discard any held vadd operand
- i_clr_sat  in  1  clear sticky saturation flag
- o_wb_data  out  DATA_W  result vector
- o_wb_v  out  1  result valid, single-cycle pulse per result
- o_wb_idx  out  IDX_W  result regfile index
- o_wb_mux  out  MUX_W  result regfile mux select
- o_pend  out  1  an operand A is held (state HOLD_A)
- o_sat  out  1  sticky: at least one lane saturated since last clear

Behaviour:
- Single clock, clk rising edge. rst is synchronous and active-high.
- Reset values: o_wb_v=0, o_pend=0, o_sat=0, o_wb_data=0, o_wb_idx=0, o_wb_mux=0, state=IDLE, operand register=0.
- Accepted beat: i_data_v & i_en_simd. Any beat with i_en_simd=0 is ignored entirely; no state change.
- FSM states: IDLE, HOLD_A.
- IDLE, accepted beat with vadd=1:
  - Latch i_data into opA; go to HOLD_A; no output.
  - i_en_relu, i_rf_idx and i_rf_mux of this first beat are ignored.
- HOLD_A, accepted beat with vadd=1:
  - result lane k = sat8(opA[k] + i_data[k]). The 9-bit signed sum is clamped to [-128, 127].
  - If i_en_relu=1, negative result lanes are forced to 0 after saturation.
  - Output uses this beat's i_rf_idx / i_rf_mux. Return to IDLE.
- Accepted beat with vadd=0, in either state:
  - Result = ReLU(i_data) if i_en_relu=1, else i_data unchanged (pass-through).
  - Output uses this beat's idx/mux. The FSM state and opA are unchanged.
- Latency: exactly 1 cycle from the accepted completing beat to o_wb_v=1, with data/idx/mux registered alongside it.
- o_wb_v is 0 in every cycle without a completing beat. o_wb_data/idx/mux hold their last value when o_wb_v=0.
- No backpressure: the downstream regfile write always accepts. Back-to-back beats are sustained at 1 per cycle.
- o_pend = (state == HOLD_A), registered.
- i_flush:
  - Forces state to IDLE and discards opA in the same cycle. Takes priority over a vadd beat arriving in that cycle, which is also discarded.
  - A vadd=0 beat in the flush cycle is still processed.
- o_sat:
  - Set when any lane of an emitted vadd result was clamped; ReLU zeroing does not count.
  - i_clr_sat clears it. If clear and set occur in the same cycle, set wins.
- A reset asserted while in HOLD_A drops the held operand. No output is produced for it.

Decomposition:
- Shared package simd_pkg holds:
  - constants DATA_W, LANE_W, NLANE, IDX_W, MUX_W
  - state enum {IDLE, HOLD_A}
  - sat8 function (9-bit signed to 8-bit clamp)
  - relu8 function
- One natural sub-module: simd_lane_alu, a combinational per-lane add/saturate/relu block that also emits a per-lane sat bit. It is instantiated NLANE times via generate.

Test Plan:
- Pass-through: rst; beat en_simd=1, vadd=0, relu=0, data lanes 0x80,0x7F,... idx=3 mux=1 -> next cycle o_wb_v=1, identical data, o_wb_idx=3, o_wb_mux=1, o_sat=0.
- ReLU only: all lanes 0xF0 (-16) with lane0=0x05, relu=1 -> lane0=0x05, other lanes 0x00, 1-cycle latency.
- Vadd with saturation:
  - Beat A all 0x70, then beat B all 0x20, relu=0, idx=7 -> o_wb_v only after B, all lanes 0x7F, o_wb_idx=7, o_sat=1.
  - Then i_clr_sat -> o_sat=0.
- Vadd + ReLU with negative overflow: A all 0x90 (-112), B all 0xE0 (-32), relu=1 -> sum clamps to 0x80, then ReLU -> lanes 0x00; o_sat=1.
- Interleave and flush:
  - Sequence A(vadd), pass-through beat, B(vadd), back-to-back -> pass-through result appears while o_pend stays 1, then the sum appears; o_pend drops to 0.
  - Second sequence: A, then i_flush, then vadd beat -> no output, o_pend=1 (the post-flush vadd beat becomes the new A).
- Mid-operation reset / en_simd gating:
  - Hold A, assert rst one cycle -> o_pend=0, all outputs 0.
  - A beat with en_simd=0, data_v=1 -> no o_wb_v and no state change.
